// File: rtl/mc_control_fsm.sv
// -----------------------------------------------------------------------------
// mc_control_fsm
// Multi-cycle control sequencer for the 16-bit TSC CPU. Walks each instruction
// through IF/ID/EX/MEM/WB, drives the datapath mux selects and enable strobes,
// and handshakes with the unified instruction/data memory.
//
// Optional feature (compile-time macro):
//   INST_COUNT_EN  defined   -> num_inst counts retired instructions (wraps)
//                  undefined -> no counter, num_inst tied to 0
//
// Ports:
//   clk, reset_n        clock (rising edge), async active-low reset
//   inst                IR contents, valid from ID onward
//   mem_ack             memory finished the current read/write this cycle
//   pc_write            unconditional PC load
//   pc_write_cond       PC load if datapath branch condition is true
//   pc_source           0=ALU result, 1=ALUOut, 2=jump target
//   i_or_d              0=fetch address PC, 1=data address ALUOut
//   mem_read/mem_write  memory requests, held until mem_ack
//   ir_write            latch memory data into IR
//   reg_write           register-file write enable
//   reg_dst             0=rd, 1=rt, 2=$2 (link)
//   mem_to_reg          0=ALUOut, 1=MDR, 2=PC (link)
//   alu_src_a           0=PC, 1=rs
//   alu_src_b           0=rt, 1=const 1, 2=sign-ext imm, 3=zero-ext imm
//   alu_op              0=add/branch compare, 1=decode inst
//   output_valid        WWD strobe
//   is_halted           core halted by HLT
//   num_inst            retired-instruction count
// -----------------------------------------------------------------------------
module mc_control_fsm #(
    parameter int unsigned INST_W = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [INST_W-1:0] inst,
    input  logic              mem_ack,
    output logic              pc_write,
    output logic              pc_write_cond,
    output logic [1:0]        pc_source,
    output logic              i_or_d,
    output logic              mem_read,
    output logic              mem_write,
    output logic              ir_write,
    output logic              reg_write,
    output logic [1:0]        reg_dst,
    output logic [1:0]        mem_to_reg,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic              alu_op,
    output logic              output_valid,
    output logic              is_halted,
    output logic [CNT_W-1:0]  num_inst
);

    localparam logic [2:0] S_IF   = 3'd0;
    localparam logic [2:0] S_ID   = 3'd1;
    localparam logic [2:0] S_EX   = 3'd2;
    localparam logic [2:0] S_MEM  = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;
    localparam logic [2:0] S_HALT = 3'd5;

    localparam logic [3:0] OP_ORI   = 4'd5;
    localparam logic [3:0] OP_LHI   = 4'd6;
    localparam logic [3:0] OP_LWD   = 4'd7;
    localparam logic [3:0] OP_SWD   = 4'd8;
    localparam logic [3:0] OP_JMP   = 4'd9;
    localparam logic [3:0] OP_JAL   = 4'd10;
    localparam logic [3:0] OP_RTYPE = 4'd15;

    localparam logic [5:0] FN_JPR = 6'd25;
    localparam logic [5:0] FN_JRL = 6'd26;
    localparam logic [5:0] FN_WWD = 6'd28;
    localparam logic [5:0] FN_HLT = 6'd29;

    logic [2:0] state_q, state_d;
    logic [3:0] opcode;
    logic [5:0] funct;
    logic       is_branch, is_rtype, is_r_alu, is_lwd, is_swd;
    logic       unused_inst_bits;

    assign opcode    = inst[15:12];
    assign funct     = inst[5:0];
    assign is_branch = (opcode[3:2] == 2'b00);   // opcodes 0..3
    assign is_rtype  = (opcode == OP_RTYPE);
    assign is_r_alu  = is_rtype && (funct[5:3] == 3'b000);
    assign is_lwd    = (opcode == OP_LWD);
    assign is_swd    = (opcode == OP_SWD);
    assign unused_inst_bits = ^inst[11:6];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'd0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 2'd0;
        mem_to_reg    = 2'd0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_op        = 1'b0;
        output_valid  = 1'b0;
        is_halted     = 1'b0;

        case (state_q)
            S_IF: begin
                mem_read = 1'b1;
                if (mem_ack) begin
                    // PC <= PC + 1 alongside the IR load
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = 2'd1;
                    state_d   = S_ID;
                end
            end
            S_ID: begin
                // Speculatively form the branch target PC + simm into ALUOut
                alu_src_b = 2'd2;
                state_d   = S_IF;
                if (opcode == OP_JMP || opcode == OP_JAL) begin
                    pc_write  = 1'b1;
                    pc_source = 2'd2;
                    if (opcode == OP_JAL) begin
                        reg_write  = 1'b1;
                        reg_dst    = 2'd2;
                        mem_to_reg = 2'd2;
                    end
                end else if (is_rtype) begin
                    if (funct == FN_WWD) begin
                        output_valid = 1'b1;
                    end else if (funct == FN_HLT) begin
                        state_d = S_HALT;
                    end else if (is_r_alu || funct == FN_JPR || funct == FN_JRL) begin
                        state_d = S_EX;
                    end
                end else if (opcode <= OP_SWD) begin
                    // branches, ADI/ORI/LHI, LWD/SWD
                    state_d = S_EX;
                end
            end
            S_EX: begin
                alu_op    = 1'b1;
                alu_src_a = 1'b1;
                state_d   = S_IF;
                if (is_branch) begin
                    alu_op        = 1'b0;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'd1;
                end else if (is_rtype) begin
                    if (funct == FN_JPR || funct == FN_JRL) begin
                        pc_write = 1'b1;
                        if (funct == FN_JRL) begin
                            reg_write  = 1'b1;
                            reg_dst    = 2'd2;
                            mem_to_reg = 2'd2;
                        end
                    end else if (is_r_alu) begin
                        state_d = S_WB;
                    end
                end else begin
                    alu_src_b = (opcode == OP_ORI || opcode == OP_LHI) ? 2'd3 : 2'd2;
                    state_d   = (is_lwd || is_swd) ? S_MEM : S_WB;
                end
            end
            S_MEM: begin
                i_or_d    = 1'b1;
                mem_read  = is_lwd;
                mem_write = !is_lwd;
                if (mem_ack) begin
                    state_d = is_lwd ? S_WB : S_IF;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                if (!is_rtype) begin
                    reg_dst    = 2'd1;
                    mem_to_reg = is_lwd ? 2'd1 : 2'd0;
                end
                state_d = S_IF;
            end
            S_HALT: begin
                is_halted = 1'b1;
            end
            default: begin
                state_d = S_IF;
            end
        endcase

        // Nothing may strobe the datapath while reset is held
        if (!reset_n) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            pc_source     = 2'd0;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            reg_write     = 1'b0;
            reg_dst       = 2'd0;
            mem_to_reg    = 2'd0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'd0;
            alu_op        = 1'b0;
            output_valid  = 1'b0;
            is_halted     = 1'b0;
        end
    end

`ifdef INST_COUNT_EN
    logic             retire;
    logic [CNT_W-1:0] cnt_q;

    // An instruction retires when control returns to IF from a later stage or enters HALT
    assign retire = ((state_d == S_IF) && (state_q == S_ID || state_q == S_EX ||
                                          state_q == S_MEM || state_q == S_WB)) ||
                    ((state_d == S_HALT) && (state_q != S_HALT));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (retire) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign num_inst = cnt_q;
`else
    assign num_inst = '0;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: directed cases plus random
// instruction streams with random memory wait states, checked cycle by
// cycle against an instruction-level script of expected control outputs.
module tb_mc_control_fsm;

    localparam int unsigned CNT_W = 4;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       alu_op;
        logic       output_valid;
        logic       is_halted;
    } ctl_t;

    typedef enum {KBr, KImm, KLwd, KSwd, KJmp, KJal, KR, KJpr, KJrl, KWwd, KHlt, KNop} kind_e;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [15:0]      inst;
    logic             mem_ack;
    logic             pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic             reg_write, alu_src_a, alu_op, output_valid, is_halted;
    logic [1:0]       pc_source, reg_dst, mem_to_reg, alu_src_b;
    logic [CNT_W-1:0] num_inst;
    ctl_t             obs;

    int errors = 0;
    int checks = 0;
    int retired = 0;

    mc_control_fsm #(.INST_W(16), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .inst(inst), .mem_ack(mem_ack),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .output_valid(output_valid), .is_halted(is_halted), .num_inst(num_inst)
    );

    assign obs = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
                  reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                  output_valid, is_halted};

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (inst 0x%04h, t=%0t)",
                     tag, got, exp, inst, $time);
        end
    endtask

    function automatic int exp_count();
`ifdef INST_COUNT_EN
        return retired % (1 << CNT_W);
`else
        return 0;
`endif
    endfunction

    function automatic kind_e kind_of(input logic [15:0] i);
        logic [3:0] op;
        logic [5:0] fn;
        op = i[15:12];
        fn = i[5:0];
        if (op <= 4'd3) return KBr;
        if (op >= 4'd4 && op <= 4'd6) return KImm;
        if (op == 4'd7) return KLwd;
        if (op == 4'd8) return KSwd;
        if (op == 4'd9) return KJmp;
        if (op == 4'd10) return KJal;
        if (op == 4'd15) begin
            if (fn <= 6'd7) return KR;
            if (fn == 6'd25) return KJpr;
            if (fn == 6'd26) return KJrl;
            if (fn == 6'd28) return KWwd;
            if (fn == 6'd29) return KHlt;
        end
        return KNop;
    endfunction

    // Selects the behaviour leaves open in a stage are excluded from the comparison
    function automatic ctl_t sel_dc_mask();
        ctl_t m;
        m = '1;
        m.pc_source  = '0;
        m.reg_dst    = '0;
        m.mem_to_reg = '0;
        m.alu_src_a  = '0;
        m.alu_src_b  = '0;
        m.alu_op     = '0;
        return m;
    endfunction

    // One clock of stimulus; outputs are compared mid-cycle, away from the rising edge
    task automatic cyc(input logic ack, input string tag, input ctl_t exp, input ctl_t mask);
        @(negedge clk);
        mem_ack = ack;
        #1;
        check_val(tag, 32'(obs & mask), 32'(exp & mask));
    endtask

    task automatic fetch(input int if_wait, input logic [15:0] i);
        ctl_t e;
        for (int w = 0; w < if_wait; w++) begin
            e = '0;
            e.mem_read = 1'b1;
            cyc(1'b0, "if_wait", e, '1);
        end
        e = '0;
        e.mem_read  = 1'b1;
        e.ir_write  = 1'b1;
        e.pc_write  = 1'b1;
        e.alu_src_b = 2'd1;
        cyc(1'b1, "if_ack", e, '1);
        check_val("num_inst", 32'(num_inst), 32'(exp_count()));
        inst = i;
    endtask

    task automatic run_instr(input logic [15:0] i, input int if_wait, input int mem_wait);
        kind_e k;
        ctl_t  e, m;
        k = kind_of(i);
        fetch(if_wait, i);

        e = '0;
        e.alu_src_b = 2'd2;
        if (k == KJmp || k == KJal) begin
            e.pc_write  = 1'b1;
            e.pc_source = 2'd2;
        end
        if (k == KJal) begin
            e.reg_write  = 1'b1;
            e.reg_dst    = 2'd2;
            e.mem_to_reg = 2'd2;
        end
        if (k == KWwd) e.output_valid = 1'b1;
        cyc(1'($urandom_range(0, 1)), "id", e, '1);

        if (!(k inside {KJmp, KJal, KWwd, KNop, KHlt})) begin
            e = '0;
            m = '1;
            case (k)
                KBr: begin
                    e.alu_src_a     = 1'b1;
                    e.pc_write_cond = 1'b1;
                    e.pc_source     = 2'd1;
                end
                KJpr, KJrl: begin
                    e.alu_op    = 1'b1;
                    e.alu_src_a = 1'b1;
                    e.pc_write  = 1'b1;
                    m.alu_src_b = '0;
                    if (k == KJrl) begin
                        e.reg_write  = 1'b1;
                        e.reg_dst    = 2'd2;
                        e.mem_to_reg = 2'd2;
                    end
                end
                KR: begin
                    e.alu_op    = 1'b1;
                    e.alu_src_a = 1'b1;
                end
                default: begin
                    e.alu_op    = 1'b1;
                    e.alu_src_b = (i[15:12] == 4'd5 || i[15:12] == 4'd6) ? 2'd3 : 2'd2;
                    m.alu_src_a = '0;
                end
            endcase
            cyc(1'($urandom_range(0, 1)), "ex", e, m);

            if (k == KLwd || k == KSwd) begin
                e = '0;
                e.i_or_d    = 1'b1;
                e.mem_read  = (k == KLwd);
                e.mem_write = (k == KSwd);
                for (int w = 0; w < mem_wait; w++) cyc(1'b0, "mem_wait", e, sel_dc_mask());
                cyc(1'b1, "mem_ack", e, sel_dc_mask());
            end

            if (k == KR || k == KImm || k == KLwd) begin
                e = '0;
                m = '1;
                m.pc_source = '0;
                m.alu_src_a = '0;
                m.alu_src_b = '0;
                m.alu_op    = '0;
                e.reg_write  = 1'b1;
                e.reg_dst    = (k == KR) ? 2'd0 : 2'd1;
                e.mem_to_reg = (k == KLwd) ? 2'd1 : 2'd0;
                cyc(1'($urandom_range(0, 1)), "wb", e, m);
            end
        end
        retired++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        mem_ack = 1'b1;
        #1;
        check_val("reset_outputs", 32'(obs), 32'h0);
        check_val("reset_num_inst", 32'(num_inst), 32'h0);
        @(negedge clk);
        #1;
        check_val("reset_hold_outputs", 32'(obs), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        mem_ack = 1'b0;
        retired = 0;
    endtask

    function automatic logic [15:0] rand_inst();
        logic [3:0]  op;
        logic [5:0]  fn;
        logic [15:0] r;
        int          sel;
        op = 4'($urandom_range(0, 15));
        r  = 16'($urandom);
        if (op != 4'd15) return {op, r[11:0]};
        sel = $urandom_range(0, 11);
        if (sel <= 7)       fn = 6'(sel);
        else if (sel == 8)  fn = 6'd25;
        else if (sel == 9)  fn = 6'd26;
        else if (sel == 10) fn = 6'd28;
        else                fn = 6'($urandom_range(8, 24));
        return {op, r[11:6], fn};
    endfunction

    initial begin
        ctl_t e;
        reset_n = 1'b0;
        mem_ack = 1'b0;
        inst    = 16'h0;
        #1;
        check_val("por_outputs", 32'(obs), 32'h0);
        check_val("por_num_inst", 32'(num_inst), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed: ADI, LWD with withheld ack, BEQ, JAL, WWD, JRL, SWD, undefined opcode
        run_instr(16'h4405, 0, 0);
        run_instr(16'h7123, 1, 3);
        run_instr(16'h1234, 0, 0);
        run_instr(16'hA123, 2, 0);
        run_instr(16'hF01C, 0, 0);
        run_instr(16'hF05A, 0, 0);
        run_instr(16'h8055, 0, 2);
        run_instr(16'hB000, 0, 0);
        run_instr(16'h6FFF, 0, 0);

        // 17 ADIs from a clean reset: counter wraps through zero
        do_reset();
        for (int n = 0; n < 17; n++) run_instr(16'h4405, 0, 0);
        fetch(0, 16'h4405);
        retired++;
        e = '0;
        e.alu_src_b = 2'd2;
        cyc(1'b0, "id_after_wrap", e, '1);

        // Reset in the middle of an LWD abandons it
        do_reset();
        fetch(0, 16'h7001);
        @(negedge clk);
        @(negedge clk);
        do_reset();
        check_val("abandon_num_inst", 32'(num_inst), 32'h0);

        // Random stream with random fetch and data wait states
        for (int n = 0; n < 200; n++) begin
            run_instr(rand_inst(), $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // HLT: parks in HALT regardless of mem_ack until reset
        run_instr(16'hF01D, 0, 0);
        e = '0;
        e.is_halted = 1'b1;
        for (int n = 0; n < 6; n++) cyc(1'($urandom_range(0, 1)), "halt", e, '1);
        check_val("halt_num_inst", 32'(num_inst), 32'(exp_count()));
        do_reset();
        run_instr(16'h4405, 0, 0);
        fetch(0, 16'h9000);
        check_val("post_halt_num_inst", 32'(num_inst), 32'(exp_count()));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
